sar_avg_sequencer: RTL and testbench

- Conversion sequencer and averager that sits directly between the system and the `sar` digital controller.
- Issues toggle-encoded start-of-conversion requests and resynchronises the toggle-encoded eoc/err/warn returns.
- Accumulates 2^AVG_LOG2 consecutive `sar_code` values and delivers one averaged, threshold-checked result per burst.
- Supports single-shot and periodic modes, plus a watchdog on every conversion.

---
 rtl/sar_avg_sequencer.sv | 179 +++++++++++++++++
 tb/tb_sar_avg_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sar_avg_sequencer.sv
// sar_avg_sequencer: drives the toggle-handshake SAR controller and averages 2^AVG_LOG2 codes per burst.
// Flags each burst result against a hi/lo threshold window.  rev 1.0
`default_nettype none

module sar_avg_sequencer #(
  parameter int NBITS    = 10,
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT  = 255,
  parameter int PERIOD_W = 16
) (
  input  logic                f100m_clk,
  input  logic                rstb,
  input  logic                start,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  input  logic [NBITS-1:0]    thr_hi,
  input  logic [NBITS-1:0]    thr_lo,
  output logic                sar_soc,
  input  logic                sar_eoc,
  input  logic                sar_err,
  input  logic                sar_warn,
  input  logic [NBITS-1:0]    sar_code,
  output logic                busy,
  output logic                res_valid,
  output logic [NBITS-1:0]    res_data,
  output logic                res_warn,
  output logic                res_above,
  output logic                res_below,
  output logic                err_pulse,
  output logic                tmo_pulse
);

  localparam int ACC_W = NBITS + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int WD_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((2 ** AVG_LOG2) - 1);
  localparam logic [WD_W-1:0]  WD_INIT  = WD_W'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t              state;
  logic [ACC_W-1:0]    acc;
  logic [CNT_W-1:0]    cnt;
  logic [WD_W-1:0]     wdog;
  logic [PERIOD_W-1:0] pcnt;
  logic                warn_flag;

  // [0],[1] are the synchroniser, [2] is the history flop for edge detection
  logic [2:0] eoc_sync;
  logic [2:0] err_sync;
  logic [2:0] warn_sync;

  logic             eoc_evt;
  logic             err_evt;
  logic             warn_evt;
  logic [ACC_W-1:0] acc_shift;
  logic [NBITS-1:0] avg;

  assign eoc_evt   = eoc_sync[1]  ^ eoc_sync[2];
  assign err_evt   = err_sync[1]  ^ err_sync[2];
  assign warn_evt  = warn_sync[1] ^ warn_sync[2];
  assign acc_shift = acc >> AVG_LOG2;
  assign avg       = acc_shift[NBITS-1:0];

  always_ff @(posedge f100m_clk or negedge rstb) begin
    if (!rstb) begin
      eoc_sync  <= '0;
      err_sync  <= '0;
      warn_sync <= '0;
    end else begin
      eoc_sync  <= {eoc_sync[1:0],  sar_eoc};
      err_sync  <= {err_sync[1:0],  sar_err};
      warn_sync <= {warn_sync[1:0], sar_warn};
    end
  end

  always_ff @(posedge f100m_clk or negedge rstb) begin
    if (!rstb) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      wdog      <= '0;
      pcnt      <= '0;
      warn_flag <= 1'b0;
      sar_soc   <= 1'b0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_warn  <= 1'b0;
      res_above <= 1'b0;
      res_below <= 1'b0;
      err_pulse <= 1'b0;
      tmo_pulse <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      err_pulse <= 1'b0;
      tmo_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (start || enable) begin
            acc       <= '0;
            cnt       <= '0;
            warn_flag <= 1'b0;
            busy      <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          sar_soc <= ~sar_soc;
          wdog    <= WD_INIT;
          state   <= WAIT;
        end
        WAIT: begin
          if (warn_evt) begin
            warn_flag <= 1'b1;
          end
          // err beats eoc, eoc beats watchdog expiry
          if (err_evt) begin
            err_pulse <= 1'b1;
            acc       <= '0;
            pcnt      <= period;
            state     <= GAP;
          end else if (eoc_evt) begin
            acc <= acc + ACC_W'(sar_code);
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_LAST) begin
              state <= DONE;
            end else begin
              state <= START;
            end
          end else if (wdog == '0) begin
            tmo_pulse <= 1'b1;
            pcnt      <= period;
            state     <= GAP;
          end else begin
            wdog <= wdog - WD_W'(1);
          end
        end
        DONE: begin
          res_valid <= 1'b1;
          res_data  <= avg;
          res_warn  <= warn_flag;
          res_above <= (avg > thr_hi);
          res_below <= (avg < thr_lo);
          pcnt      <= period;
          state     <= GAP;
        end
        GAP: begin
          if (pcnt == '0) begin
            if (enable) begin
              acc       <= '0;
              cnt       <= '0;
              warn_flag <= 1'b0;
              state     <= START;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            pcnt <= pcnt - PERIOD_W'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sar_avg_sequencer.sv
// tb_sar_avg_sequencer: directed bench for sar_avg_sequencer with a toggle-handshake SAR model.
// rev 1.0
`default_nettype none

module tb_sar_avg_sequencer;

  localparam int NB  = 10;
  localparam int TMO = 255;

  logic          f100m_clk = 1'b0;
  logic          rstb      = 1'b0;
  logic          start     = 1'b0;
  logic          enable    = 1'b0;
  logic [15:0]   period    = '0;
  logic [NB-1:0] thr_hi    = '0;
  logic [NB-1:0] thr_lo    = '0;
  logic          sar_soc;
  logic          sar_eoc   = 1'b0;
  logic          sar_err   = 1'b0;
  logic          sar_warn  = 1'b0;
  logic [NB-1:0] sar_code  = '0;
  logic          busy;
  logic          res_valid;
  logic [NB-1:0] res_data;
  logic          res_warn;
  logic          res_above;
  logic          res_below;
  logic          err_pulse;
  logic          tmo_pulse;

  sar_avg_sequencer #(
    .NBITS(NB), .AVG_LOG2(2), .TIMEOUT(TMO), .PERIOD_W(16)
  ) dut (
    .f100m_clk(f100m_clk), .rstb(rstb), .start(start), .enable(enable),
    .period(period), .thr_hi(thr_hi), .thr_lo(thr_lo),
    .sar_soc(sar_soc), .sar_eoc(sar_eoc), .sar_err(sar_err), .sar_warn(sar_warn),
    .sar_code(sar_code), .busy(busy), .res_valid(res_valid), .res_data(res_data),
    .res_warn(res_warn), .res_above(res_above), .res_below(res_below),
    .err_pulse(err_pulse), .tmo_pulse(tmo_pulse)
  );

  always #5 f100m_clk = ~f100m_clk;

  int cyc = 0;
  always @(posedge f100m_clk) cyc <= cyc + 1;

  // SAR model configuration (written by the stimulus only)
  int            lat      = 2;
  bit            silent   = 1'b0;
  bit            coincide = 1'b0;
  int            err_idx  = 99;
  int            warn_idx = 99;
  int            base     = 0;
  int            inj_req  = 0;
  logic [NB-1:0] codes [4];

  // SAR model state (written by the model only)
  int   nreq     = 0;
  int   inj_ack  = 0;
  logic prev_soc = 1'b0;
  bit   pending  = 1'b0;
  int   dly      = 0;
  int   rel      = 0;

  always @(negedge f100m_clk) begin
    if (!rstb) begin
      prev_soc = 1'b0;
      pending  = 1'b0;
      sar_eoc  = 1'b0;
      sar_err  = 1'b0;
      sar_warn = 1'b0;
    end else begin
      if (inj_req != inj_ack) begin
        inj_ack  = inj_req;
        sar_code = 10'd999;
        sar_eoc  = ~sar_eoc;
      end
      if (sar_soc != prev_soc) begin
        prev_soc = sar_soc;
        pending  = 1'b1;
        dly      = lat;
        rel      = nreq - base;
        nreq     = nreq + 1;
      end
      if (pending) begin
        if (dly == 0) begin
          pending = 1'b0;
          if (!silent) begin
            if (rel == err_idx) begin
              sar_err = ~sar_err;
              if (coincide) begin
                sar_code = codes[rel % 4];
                sar_eoc  = ~sar_eoc;
              end
            end else begin
              sar_code = codes[rel % 4];
              sar_eoc  = ~sar_eoc;
              if (rel == warn_idx) sar_warn = ~sar_warn;
            end
          end
        end else begin
          dly = dly - 1;
        end
      end
    end
  end

  int rv_cnt = 0, err_cnt = 0, tmo_cnt = 0, rv_last = 0, rv_prev = 0;
  always @(negedge f100m_clk) begin
    if (rstb) begin
      if (res_valid) begin
        rv_cnt  = rv_cnt + 1;
        rv_prev = rv_last;
        rv_last = cyc;
      end
      if (err_pulse) err_cnt = err_cnt + 1;
      if (tmo_pulse) tmo_cnt = tmo_cnt + 1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge f100m_clk);
    #1;
  endtask

  int b_rv, b_err, b_tmo;
  task automatic snap();
    b_rv  = rv_cnt;
    b_err = err_cnt;
    b_tmo = tmo_cnt;
    base  = nreq;
  endtask

  task automatic set_codes(input logic [NB-1:0] c0, c1, c2, c3);
    codes[0] = c0; codes[1] = c1; codes[2] = c2; codes[3] = c3;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy && n < bound) begin
      tick();
      n++;
    end
    check_val("idle_reached", {31'd0, busy}, 32'd0);
  endtask

  task automatic run_burst();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    wait_idle(2000);
  endtask

  int t_a, t_b, n;
  logic soc0;

  initial begin
    tick(); tick(); tick();
    check_val("rst_busy",  {31'd0, busy},      32'd0);
    check_val("rst_soc",   {31'd0, sar_soc},   32'd0);
    check_val("rst_valid", {31'd0, res_valid}, 32'd0);
    check_val("rst_data",  32'(res_data),      32'd0);
    rstb = 1'b1;
    tick(); tick();

    // basic average of 100..103
    thr_hi = 10'd1000; thr_lo = 10'd0;
    set_codes(10'd100, 10'd101, 10'd102, 10'd103);
    snap();
    run_burst();
    check_val("t1_soc_toggles", 32'(nreq - base),   32'd4);
    check_val("t1_valid_cnt",   32'(rv_cnt - b_rv), 32'd1);
    check_val("t1_data",        32'(res_data),      32'd101);
    check_val("t1_above",       {31'd0, res_above}, 32'd0);
    check_val("t1_below",       {31'd0, res_below}, 32'd0);

    // full-scale and zero codes against the threshold window
    thr_lo = 10'd5;
    set_codes(10'd1023, 10'd1023, 10'd1023, 10'd1023);
    run_burst();
    check_val("t2_max_data",  32'(res_data),      32'd1023);
    check_val("t2_max_above", {31'd0, res_above}, 32'd1);
    check_val("t2_max_below", {31'd0, res_below}, 32'd0);
    set_codes(10'd0, 10'd0, 10'd0, 10'd0);
    run_burst();
    check_val("t2_zero_data",  32'(res_data),      32'd0);
    check_val("t2_zero_below", {31'd0, res_below}, 32'd1);
    check_val("t2_zero_above", {31'd0, res_above}, 32'd0);

    // silent SAR: watchdog abort
    silent = 1'b1;
    snap();
    soc0  = sar_soc;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    do begin tick(); n++; end while (sar_soc == soc0 && n < 20);
    t_a = cyc;
    n = 0;
    while (tmo_cnt == b_tmo && n < 600) begin tick(); n++; end
    t_b = cyc;
    check_val("t3_tmo_seen",    32'(tmo_cnt - b_tmo), 32'd1);
    check_val("t3_tmo_latency", 32'(t_b - t_a),       32'(TMO + 1));
    wait_idle(100);
    check_val("t3_no_valid",    32'(rv_cnt - b_rv),   32'd0);
    check_val("t3_data_held",   32'(res_data),        32'd0);
    // late eoc arriving in IDLE must be dropped
    inj_req = inj_req + 1;
    repeat (10) tick();
    check_val("t3_late_no_valid", 32'(rv_cnt - b_rv), 32'd0);
    check_val("t3_late_idle",     {31'd0, busy},      32'd0);
    silent = 1'b0;
    set_codes(10'd10, 10'd20, 10'd30, 10'd40);
    snap();
    run_burst();
    check_val("t3_next_data",  32'(res_data),      32'd25);
    check_val("t3_next_valid", 32'(rv_cnt - b_rv), 32'd1);

    // err on the second conversion
    err_idx = 1;
    snap();
    run_burst();
    check_val("t4_err_pulse", 32'(err_cnt - b_err), 32'd1);
    check_val("t4_no_valid",  32'(rv_cnt - b_rv),   32'd0);
    check_val("t4_soc_cnt",   32'(nreq - base),     32'd2);
    check_val("t4_data_held", 32'(res_data),        32'd25);
    // err and eoc in the same cycle
    err_idx = 0; coincide = 1'b1;
    snap();
    run_burst();
    check_val("t4c_err_pulse", 32'(err_cnt - b_err), 32'd1);
    check_val("t4c_no_valid",  32'(rv_cnt - b_rv),   32'd0);
    check_val("t4c_data_held", 32'(res_data),        32'd25);
    err_idx = 99; coincide = 1'b0;

    // periodic mode
    period = 16'd100;
    set_codes(10'd200, 10'd200, 10'd200, 10'd204);
    snap();
    enable = 1'b1;
    n = 0;
    while ((rv_cnt - b_rv) < 2 && n < 2000) begin tick(); n++; end
    check_val("t5_two_valid", 32'(rv_cnt - b_rv),    32'd2);
    check_val("t5_spacing",   32'(rv_last - rv_prev), 32'd126);
    check_val("t5_data",      32'(res_data),          32'd201);
    repeat (110) tick();
    enable = 1'b0;
    wait_idle(2000);
    check_val("t5_last_valid", 32'(rv_cnt - b_rv), 32'd3);
    check_val("t5_soc_cnt",    32'(nreq - base),   32'd12);
    repeat (200) tick();
    check_val("t5_stays_idle", {31'd0, busy},      32'd0);
    check_val("t5_no_more",    32'(rv_cnt - b_rv), 32'd3);

    // warn on one conversion marks that result only
    period = 16'd0;
    set_codes(10'd8, 10'd8, 10'd8, 10'd8);
    warn_idx = 2;
    snap();
    run_burst();
    check_val("t6_warn_set",  {31'd0, res_warn}, 32'd1);
    check_val("t6_warn_data", 32'(res_data),     32'd8);
    warn_idx = 99;
    snap();
    run_burst();
    check_val("t6_warn_clr",  {31'd0, res_warn}, 32'd0);

    // reset while waiting on a silent SAR
    silent = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    rstb = 1'b0;
    #1;
    check_val("t7_busy",  {31'd0, busy},      32'd0);
    check_val("t7_soc",   {31'd0, sar_soc},   32'd0);
    check_val("t7_data",  32'(res_data),      32'd0);
    check_val("t7_warn",  {31'd0, res_warn},  32'd0);
    check_val("t7_above", {31'd0, res_above}, 32'd0);
    check_val("t7_tmo",   {31'd0, tmo_pulse}, 32'd0);
    tick(); tick();
    rstb = 1'b1;
    silent = 1'b0;
    tick();
    set_codes(10'd100, 10'd101, 10'd102, 10'd103);
    snap();
    run_burst();
    check_val("t7_recover_data",  32'(res_data),      32'd101);
    check_val("t7_recover_valid", 32'(rv_cnt - b_rv), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
